// File: rtl/z80_block_xfer_seq.sv
// z80_block_xfer_seq: Z80 LDI/LDD/LDIR/LDDR block-transfer sequencer.
// Moves one byte per iteration from (HL) to (DE) over split read/write
// req/ack buses, then steps BC/DE/HL and the flags.
// Optional feature macro: Z80_BLOCK_XFER_INT_EN (interrupt break-out of
// repeating transfers, exiting with ip_advance=0 so the opcode refetches).
module z80_block_xfer_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [15:0] bc_in,
  input  logic [15:0] de_in,
  input  logic [15:0] hl_in,
  input  logic [7:0]  f_in,
  output logic        mem_rd_req,
  output logic [15:0] mem_rd_addr,
  input  logic        mem_rd_ack,
  input  logic [7:0]  mem_rdata,
  output logic        mem_wr_req,
  output logic [15:0] mem_wr_addr,
  output logic [7:0]  mem_wr_data,
  input  logic        mem_wr_ack,
  input  logic        int_pending,
  output logic [15:0] bc_out,
  output logic [15:0] de_out,
  output logic [15:0] hl_out,
  output logic [7:0]  f_out,
  output logic        busy,
  output logic        done,
  output logic        ip_advance
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_bc;
  logic [15:0] r_de;
  logic [15:0] r_hl;
  logic [7:0]  r_f;
  logic [1:0]  r_op;
  logic [7:0]  r_data;
  logic        r_ipadv;

  logic [15:0] w_bc_dec;
  logic [15:0] w_de_step;
  logic [15:0] w_hl_step;
  logic        w_bc_nz;
  logic        w_int_break;

  // Register steps: BC always counts down, DE/HL follow the direction bit.
  assign w_bc_dec  = r_bc - 16'd1;
  assign w_bc_nz   = (w_bc_dec != '0);
  assign w_de_step = r_op[0] ? (r_de - 16'd1) : (r_de + 16'd1);
  assign w_hl_step = r_op[0] ? (r_hl - 16'd1) : (r_hl + 16'd1);

`ifdef Z80_BLOCK_XFER_INT_EN
  assign w_int_break = int_pending;
`else
  logic w_unused_int;
  assign w_int_break  = 1'b0;
  assign w_unused_int = int_pending;
`endif

  // Working registers drive the outputs continuously.
  assign bc_out      = r_bc;
  assign de_out      = r_de;
  assign hl_out      = r_hl;
  assign f_out       = r_f;
  assign mem_rd_addr = r_hl;
  assign mem_wr_addr = r_de;
  assign mem_wr_data = r_data;
  assign ip_advance  = done & r_ipadv;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and bus/status outputs.
  always_comb begin
    w_next     = r_state;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_READ;
      end
      S_READ: begin
        mem_rd_req = 1'b1;
        if (mem_rd_ack) w_next = S_WRITE;
      end
      S_WRITE: begin
        mem_wr_req = 1'b1;
        if (mem_wr_ack) w_next = S_UPDATE;
      end
      S_UPDATE: begin
        if (r_op[1] && w_bc_nz && !w_int_break) w_next = S_READ;
        else                                    w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture on start, latch read byte, step registers and flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bc    <= '0;
      r_de    <= '0;
      r_hl    <= '0;
      r_f     <= '0;
      r_op    <= '0;
      r_data  <= '0;
      r_ipadv <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bc <= bc_in;
            r_de <= de_in;
            r_hl <= hl_in;
            r_f  <= f_in;
            r_op <= op;
          end
        end
        S_READ: begin
          if (mem_rd_ack) r_data <= mem_rdata;
        end
        S_UPDATE: begin
          r_bc    <= w_bc_dec;
          r_de    <= w_de_step;
          r_hl    <= w_hl_step;
          // H and N cleared, PV reports BC!=0, other flags pass through.
          r_f     <= {r_f[7:5], 1'b0, r_f[3], w_bc_nz, 1'b0, r_f[0]};
          // Only an interrupt break-out leaves the opcode to be refetched.
          r_ipadv <= !(r_op[1] && w_bc_nz && w_int_break);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_block_xfer_seq.sv
// Self-checking bench for z80_block_xfer_seq: constant vector table,
// randomized runs against a transfer-level reference model, and
// hand-written reset / wrap / interrupt sequences.
module tb_z80_block_xfer_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  op;
  logic [15:0] bc_in, de_in, hl_in;
  logic [7:0]  f_in;
  logic        mem_rd_req, mem_rd_ack;
  logic [15:0] mem_rd_addr;
  logic [7:0]  mem_rdata;
  logic        mem_wr_req, mem_wr_ack;
  logic [15:0] mem_wr_addr;
  logic [7:0]  mem_wr_data;
  logic        int_pending;
  logic [15:0] bc_out, de_out, hl_out;
  logic [7:0]  f_out;
  logic        busy, done, ip_advance;

  int checks = 0;
  int errors = 0;

  z80_block_xfer_seq dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .bc_in(bc_in), .de_in(de_in), .hl_in(hl_in), .f_in(f_in),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_ack(mem_rd_ack), .mem_rdata(mem_rdata),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .mem_wr_ack(mem_wr_ack),
    .int_pending(int_pending),
    .bc_out(bc_out), .de_out(de_out), .hl_out(hl_out), .f_out(f_out),
    .busy(busy), .done(done), .ip_advance(ip_advance)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Memory, responder and write log
  logic [7:0]  mem [65536];
  logic [7:0]  mm  [65536];
  logic [15:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  int          lat  = 0;
  bit          spur = 1'b0;
  int          rd_wait = 0, wr_wait = 0;
  logic [15:0] rd_hold, wr_hold_a;
  logic [7:0]  wr_hold_d;

  // Ack responder with programmable latency; stray acks when no req.
  always @(negedge clk) begin
    chk("rd_wr_overlap", {31'd0, mem_rd_req & mem_wr_req}, 32'd0);
    if (mem_rd_req) begin
      if (rd_wait == 0) rd_hold = mem_rd_addr;
      else chk("rd_addr_stable", {16'd0, mem_rd_addr}, {16'd0, rd_hold});
      if (rd_wait >= lat) begin
        mem_rd_ack = 1'b1;
        mem_rdata  = mem[mem_rd_addr];
      end else begin
        mem_rd_ack = 1'b0;
        mem_rdata  = 8'($urandom);
      end
      rd_wait++;
    end else begin
      rd_wait    = 0;
      mem_rd_ack = spur ? 1'($urandom) : 1'b0;
      mem_rdata  = 8'($urandom);
    end
    if (mem_wr_req) begin
      if (wr_wait == 0) begin
        wr_hold_a = mem_wr_addr;
        wr_hold_d = mem_wr_data;
      end else begin
        chk("wr_addr_stable", {16'd0, mem_wr_addr}, {16'd0, wr_hold_a});
        chk("wr_data_stable", {24'd0, mem_wr_data}, {24'd0, wr_hold_d});
      end
      mem_wr_ack = (wr_wait >= lat);
      wr_wait++;
    end else begin
      wr_wait    = 0;
      mem_wr_ack = spur ? 1'($urandom) : 1'b0;
    end
  end

  // Completed write handshakes update memory and the log.
  always @(posedge clk) begin
    if (reset_n && mem_wr_req && mem_wr_ack) begin
      wq_addr.push_back(mem_wr_addr);
      wq_data.push_back(mem_wr_data);
      mem[mem_wr_addr] = mem_wr_data;
    end
  end

  logic [15:0] res_bc, res_de, res_hl;
  logic [7:0]  res_f;
  logic        res_ip;
  int          res_n;

  // Run one instruction and compare against the transfer-level model.
  task automatic run_op(input logic [1:0] o, input logic [15:0] bc,
                        input logic [15:0] de, input logic [15:0] hl,
                        input logic [7:0] f, input int l, input bit inject,
                        input bit intp);
    int total, n, cyc, exp_cyc;
    bit eip, got;
    logic [15:0] ebc, ede, ehl, src, dst;
    logic [7:0]  ef;
    logic [15:0] ea[$];
    logic [7:0]  ed[$];
    total = o[1] ? ((bc == 16'd0) ? 65536 : int'(bc)) : 1;
    n = total;
    eip = 1'b1;
`ifdef Z80_BLOCK_XFER_INT_EN
    if (o[1] && intp && total > 1) begin
      n   = 1;
      eip = 1'b0;
    end
`endif
    mm = mem;
    for (int k = 0; k < n; k++) begin
      src = 16'(int'(hl) + (o[0] ? -k : k));
      dst = 16'(int'(de) + (o[0] ? -k : k));
      ea.push_back(dst);
      ed.push_back(mm[src]);
      mm[dst] = mm[src];
    end
    ebc = 16'(int'(bc) - n);
    ehl = 16'(int'(hl) + (o[0] ? -n : n));
    ede = 16'(int'(de) + (o[0] ? -n : n));
    ef  = (f & 8'hE9) | ((ebc != 16'd0) ? 8'h04 : 8'h00);
    exp_cyc = 1 + n * (2 * (l + 1) + 1);

    lat = l;
    int_pending = intp;
    wq_addr.delete();
    wq_data.delete();
    op = o; bc_in = bc; de_in = de; hl_in = hl; f_in = f;
    start = 1'b1;
    cyc = 0;
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      cyc++;
      start = (inject && cyc == 1);
      if (start) begin
        op = 2'($urandom); bc_in = 16'($urandom);
        de_in = 16'($urandom); hl_in = 16'($urandom); f_in = 8'($urandom);
      end
      if (cyc == 1) chk("busy_running", {31'd0, busy}, 32'd1);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    if (!got) begin
      reset_n = 1'b0; #1; reset_n = 1'b1;
      return;
    end
    res_bc = bc_out; res_de = de_out; res_hl = hl_out; res_f = f_out;
    res_ip = ip_advance; res_n = wq_addr.size();
    chk("done_latency", cyc, exp_cyc);
    chk("bc_out", {16'd0, bc_out}, {16'd0, ebc});
    chk("de_out", {16'd0, de_out}, {16'd0, ede});
    chk("hl_out", {16'd0, hl_out}, {16'd0, ehl});
    chk("f_out", {24'd0, f_out}, {24'd0, ef});
    chk("ip_advance", {31'd0, ip_advance}, {31'd0, eip});
    chk("write_count", res_n, n);
    for (int k = 0; k < n && k < res_n; k++) begin
      chk("wr_addr", {16'd0, wq_addr[k]}, {16'd0, ea[k]});
      chk("wr_data", {24'd0, wq_data[k]}, {24'd0, ed[k]});
    end
    @(posedge clk); #1;
    chk("done_one_cycle", {30'd0, done, busy}, 32'd0);
    chk("ip_after_done", {31'd0, ip_advance}, 32'd0);
    int_pending = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] bc, de, hl;
    logic [7:0]  f;
    int          lat;
    logic [15:0] ebc, ede, ehl;
    logic [7:0]  ef;
    logic        eip;
    int          en;
  } vec_t;

  vec_t tv [7];

  initial begin
    tv[0] = '{2'd0, 16'h0003, 16'h2000, 16'h1000, 8'hFF, 0, 16'h0002, 16'h2001, 16'h1001, 8'hED, 1'b1, 1};
    tv[1] = '{2'd2, 16'h0003, 16'h2000, 16'h1000, 8'h00, 0, 16'h0000, 16'h2003, 16'h1003, 8'h00, 1'b1, 3};
    tv[2] = '{2'd3, 16'h0002, 16'h0000, 16'h0001, 8'h00, 0, 16'h0000, 16'hFFFE, 16'hFFFF, 8'h00, 1'b1, 2};
    tv[3] = '{2'd1, 16'h0001, 16'hFFFF, 16'h0000, 8'h16, 0, 16'h0000, 16'hFFFE, 16'hFFFF, 8'h00, 1'b1, 1};
    tv[4] = '{2'd0, 16'h0000, 16'h8000, 16'hFFFF, 8'hC1, 0, 16'hFFFF, 16'h8001, 16'h0000, 8'hC5, 1'b1, 1};
    tv[5] = '{2'd2, 16'h0001, 16'h4001, 16'h4000, 8'h29, 1, 16'h0000, 16'h4002, 16'h4001, 8'h29, 1'b1, 1};
    tv[6] = '{2'd0, 16'h0003, 16'h2000, 16'h1000, 8'hFF, 3, 16'h0002, 16'h2001, 16'h1001, 8'hED, 1'b1, 1};

    reset_n = 1'b0; start = 1'b0; op = '0; bc_in = '0; de_in = '0;
    hl_in = '0; f_in = '0; int_pending = 1'b0;
    mem_rd_ack = 1'b0; mem_wr_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    #1;
    chk("rst_ctrl", {27'd0, mem_rd_req, mem_wr_req, busy, done, ip_advance}, 32'd0);
    chk("rst_bc_de", {bc_out, de_out}, 32'd0);
    chk("rst_hl_f", {8'd0, hl_out, f_out}, 32'd0);
    chk("rst_latch", {24'd0, mem_wr_data}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Constant vectors.
    for (int i = 0; i < 7; i++) begin
      mem[tv[i].hl] = 8'h5A;
      run_op(tv[i].op, tv[i].bc, tv[i].de, tv[i].hl, tv[i].f, tv[i].lat, 1'b0, 1'b0);
      chk("tv_bc", {16'd0, res_bc}, {16'd0, tv[i].ebc});
      chk("tv_de", {16'd0, res_de}, {16'd0, tv[i].ede});
      chk("tv_hl", {16'd0, res_hl}, {16'd0, tv[i].ehl});
      chk("tv_f", {24'd0, res_f}, {24'd0, tv[i].ef});
      chk("tv_ip", {31'd0, res_ip}, {31'd0, tv[i].eip});
      chk("tv_n", res_n, tv[i].en);
      if (res_n > 0) chk("tv_first_data", {24'd0, wq_data[0]}, 32'h5A);
    end

    // Randomized runs with stray acks, latency and ignored restarts.
    spur = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [1:0] o;
      o = 2'($urandom);
      run_op(o, o[1] ? 16'($urandom_range(1, 6)) : 16'($urandom),
             16'($urandom), 16'($urandom), 8'($urandom),
             $urandom_range(0, 3), 1'($urandom), 1'b0);
    end
    spur = 1'b0;

    // Interrupt break-out (or its absence) on a repeating transfer.
    run_op(2'd2, 16'd5, 16'h3000, 16'h3100, 8'h00, 0, 1'b0, 1'b1);
`ifdef Z80_BLOCK_XFER_INT_EN
    chk("int_n", res_n, 1);
    chk("int_bc", {16'd0, res_bc}, 32'h0004);
    chk("int_pv", {31'd0, res_f[2]}, 32'd1);
    chk("int_ip", {31'd0, res_ip}, 32'd0);
`else
    chk("noint_n", res_n, 5);
    chk("noint_bc", {16'd0, res_bc}, 32'h0000);
    chk("noint_ip", {31'd0, res_ip}, 32'd1);
`endif

    // BC=0000 repeat wraps to FFFF and keeps going; abandoned by reset.
    lat = 0;
    wq_addr.delete(); wq_data.delete();
    op = 2'd2; bc_in = 16'h0000; de_in = 16'h6000; hl_in = 16'h5000; f_in = 8'h00;
    start = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (wq_addr.size() == 3 && mem_rd_req) begin
          got = 1'b1;
          break;
        end
      end
      chk("wrap_reached", {31'd0, got}, 32'd1);
    end
    chk("wrap_bc", {16'd0, bc_out}, 32'hFFFD);
    chk("wrap_hl", {16'd0, hl_out}, 32'h5003);
    chk("wrap_de", {16'd0, de_out}, 32'h6003);
    chk("wrap_busy_pv", {30'd0, busy, f_out[2]}, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_read_req", {30'd0, mem_rd_req, busy}, 32'd0);
    chk("rst_read_bc", {16'd0, bc_out}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    // Reset during a write with the request pending.
    lat = 3;
    wq_addr.delete(); wq_data.delete();
    op = 2'd0; bc_in = 16'h0007; de_in = 16'h7000; hl_in = 16'h7100; f_in = 8'hFF;
    start = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 50; c++) begin
        @(posedge clk); #1;
        start = 1'b0;
        if (mem_wr_req) begin
          got = 1'b1;
          break;
        end
      end
      chk("wr_req_reached", {31'd0, got}, 32'd1);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("rstw_ctrl", {27'd0, mem_rd_req, mem_wr_req, busy, done, ip_advance}, 32'd0);
    chk("rstw_bc_de", {bc_out, de_out}, 32'd0);
    chk("rstw_hl_f", {8'd0, hl_out, f_out}, 32'd0);
    chk("rstw_latch", {24'd0, mem_wr_data}, 32'd0);
    repeat (2) @(posedge clk);
    chk("rstw_no_write", wq_addr.size(), 0);
    chk("rstw_idle", {30'd0, mem_rd_req, mem_wr_req}, 32'd0);
    #1 reset_n = 1'b1;
    run_op(2'd0, 16'h0003, 16'h2000, 16'h1000, 8'hFF, 0, 1'b0, 1'b0);
    chk("post_rst_bc", {16'd0, res_bc}, 32'h0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
